// File: rtl/axil_req_arbiter_if.sv
// AXI4-Lite master bus bundle used by axil_req_arbiter (AxPROT not carried).
interface axil_req_arbiter_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_req_arbiter.sv
// Shares one AXI4-Lite master port between NUM_REQ single-beat requesters, one transaction at a time.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axil_req_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                    req_resp,
    axil_req_arbiter_if.master            m_axi
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WRESP, S_RADDR, S_RDATA, S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;
    logic [IDX_W-1:0]       pick;
    logic                   any_req;

`ifndef AXIL_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]         cand;
    logic [IDX_W:0]         ptr_inc;
`endif

    always_comb begin
        pick    = '0;
        any_req = |req_valid;
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[IDX_W'(i)]) pick = IDX_W'(i);
        end
`else
        cand = '0;
        // Walk backwards so the candidate closest to the pointer is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
            if (req_valid[cand[IDX_W-1:0]]) pick = cand[IDX_W-1:0];
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifndef AXIL_ARB_FIXED_PRIO_EN
        rr_ptr_d  = rr_ptr_q;
        ptr_inc   = {1'b0, pick} + (IDX_W+1)'(1);
        if (ptr_inc == (IDX_W+1)'(NUM_REQ)) ptr_inc = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    addr_d  = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH] & ~ADDR_WIDTH'(3);
                    wdata_d = req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
`ifndef AXIL_ARB_FIXED_PRIO_EN
                    rr_ptr_d = ptr_inc[IDX_W-1:0];
`endif
                    if (req_we[pick]) begin
                        state_d   = S_WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = S_RADDR;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; move on once neither is pending.
                awvalid_d = awvalid_q & ~m_axi.awready;
                wvalid_d  = wvalid_q & ~m_axi.wready;
                if (!awvalid_d && !wvalid_d) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (m_axi.bvalid) begin
                    resp_d  = m_axi.bresp;
                    state_d = S_DONE;
                end
            end
            S_RADDR: begin
                if (m_axi.arready) state_d = S_RDATA;
            end
            S_RDATA: begin
                if (m_axi.rvalid) begin
                    rdata_d = m_axi.rdata;
                    resp_d  = m_axi.rresp;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
`ifndef AXIL_ARB_FIXED_PRIO_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    always_comb begin
        req_done = '0;
        if (state_q == S_DONE) req_done[grant_q] = 1'b1;
    end

    assign req_rdata     = rdata_q;
    assign req_resp      = resp_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = (state_q == S_WRESP);
    assign m_axi.arvalid = (state_q == S_RADDR);
    assign m_axi.rready  = (state_q == S_RDATA);
endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: AXI4-Lite slave model plus expected-completion queue.
module tb_axil_req_arbiter;
    localparam int N  = 3;
    localparam int AW = 4;
    localparam int DW = 32;

    logic            ACLK    = 1'b0;
    logic            ARESETN = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we    = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_done;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_resp;

    axil_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    axil_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .req_resp  (req_resp),
        .m_axi     (axi)
    );

    always #5 ACLK = ~ACLK;

    // ---------------- slave model ----------------
    int          w_delay   = 0;
    logic        b_hold    = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00;
    int          w_cnt;
    int          b_count   = 0;
    logic        aw_f, w_f;
    logic [3:0]  aw_a;
    logic [31:0] w_d;
    logic [31:0] sregs [4];

    wire        aw_hs = axi.awvalid & axi.awready;
    wire        w_hs  = axi.wvalid & axi.wready;
    wire        aw_n  = aw_f | aw_hs;
    wire        w_n   = w_f | w_hs;
    wire [3:0]  wa    = aw_hs ? axi.awaddr : aw_a;
    wire [31:0] wd    = w_hs ? axi.wdata : w_d;

    assign axi.awready = 1'b1;
    assign axi.arready = 1'b1;
    assign axi.wready  = axi.wvalid && (w_cnt >= w_delay);

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.rvalid <= 1'b0;
            axi.rdata  <= '0;
            axi.rresp  <= 2'b00;
            aw_f <= 1'b0; w_f <= 1'b0; aw_a <= '0; w_d <= '0; w_cnt <= 0;
        end else begin
            if (aw_hs) aw_a <= axi.awaddr;
            if (w_hs)  w_d  <= axi.wdata;
            if (aw_n && w_n && !axi.bvalid && !b_hold) begin
                sregs[wa[3:2]] <= wd;
                axi.bvalid <= 1'b1;
                axi.bresp  <= bresp_cfg;
                aw_f <= 1'b0; w_f <= 1'b0;
            end else begin
                aw_f <= aw_n; w_f <= w_n;
                if (axi.bvalid && axi.bready) begin
                    axi.bvalid <= 1'b0;
                    b_count    <= b_count + 1;
                end
            end
            if (w_hs) w_cnt <= 0;
            else if (axi.wvalid) w_cnt <= w_cnt + 1;
            if (axi.arvalid && axi.arready) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= sregs[axi.araddr[3:2]];
                axi.rresp  <= 2'b00;
            end else if (axi.rvalid && axi.rready) begin
                axi.rvalid <= 1'b0;
            end
        end
    end

    // ---------------- passive monitor ----------------
    int         cyc = 0, aw_cyc = 0, w_cyc = 0, done_cnt = 0, aw_hs_cyc = 0, w_hs_cyc = 0;
    logic [3:0] ar_addr_l = '0;
    always @(posedge ACLK) cyc <= cyc + 1;
    always @(negedge ACLK) begin
        if (axi.awvalid) aw_cyc <= aw_cyc + 1;
        if (axi.wvalid)  w_cyc  <= w_cyc + 1;
        if (aw_hs) aw_hs_cyc <= cyc;
        if (w_hs)  w_hs_cyc  <= cyc;
        if (axi.arvalid && axi.arready) ar_addr_l <= axi.araddr;
        if (req_done != '0) done_cnt <= done_cnt + 1;
    end

    // ---------------- model and scoreboard ----------------
    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl_regs [4];
    logic [31:0] mdl_rdata = '0;
    int          mdl_ptr   = 0;
    int          n_checks  = 0;
    int          n_fails   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_pick(input logic [N-1:0] mask);
`ifdef AXIL_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (mask[i]) return i;
`else
        for (int k = 0; k < N; k++) if (mask[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
`endif
        return 0;
    endfunction

    task automatic set_req(input int id, input bit we, input logic [3:0] a, input logic [31:0] d);
        req_we[id]            = we;
        req_addr[id*AW +: AW] = a;
        req_wdata[id*DW +: DW] = d;
    endtask

    task automatic push_txn(input int g);
        exp_t       e;
        logic [3:0] a;
        a = req_addr[g*AW +: AW];
        e.id = g;
        if (req_we[g]) begin
            mdl_regs[a[3:2]] = req_wdata[g*DW +: DW];
            e.resp = bresp_cfg;
        end else begin
            mdl_rdata = mdl_regs[a[3:2]];
            e.resp = 2'b00;
        end
        e.rdata = mdl_rdata;
        mdl_ptr = (g + 1) % N;
        sb.push_back(e);
    endtask

    // Hold the requesters in mask for n completions, checking each against the model.
    task automatic run(input logic [N-1:0] mask, input int n, input string tag,
                       output int c0, output int first_done);
        int   prev;
        bit   got;
        exp_t e;
        @(posedge ACLK); #1;
        req_valid  = mask;
        c0         = cyc;
        prev       = 0;
        first_done = -1;
        for (int k = 0; k < n; k++) begin
            push_txn(mdl_pick(mask));
            got = 1'b0;
            for (int t = 0; t < 60 && !got; t++) begin
                @(negedge ACLK);
                if (req_done != '0) got = 1'b1;
            end
            chk({tag, " done_seen"}, 64'(got), 64'd1);
            if (!got) break;
            e = sb.pop_front();
            chk({tag, " done_vec"}, 64'(req_done), 64'd1 << e.id);
            chk({tag, " resp"}, 64'(req_resp), 64'(e.resp));
            chk({tag, " rdata"}, 64'(req_rdata), 64'(e.rdata));
            if (k == 0) first_done = cyc;
            else chk({tag, " gap"}, 64'(cyc - prev), 64'd4);
            prev = cyc;
        end
        @(posedge ACLK); #1;
        req_valid = '0;
        sb.delete();
    endtask

    initial begin
        int c0, fd, aw0, w0, b0, dn0;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            mdl_regs[i] = '0;
            sregs[i]    = '0;
        end

        // reset state
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst outs", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                             req_done, req_resp, req_rdata, axi.awaddr}), 64'd0);
        chk("wstrb", 64'(axi.wstrb), 64'hF);
        ARESETN = 1'b1;

        // single write, zero-wait slave
        set_req(0, 1'b1, 4'h0, 32'h0000_0001);
        run(3'b001, 1, "t1", c0, fd);
        chk("t1 latency", 64'(fd - c0), 64'd3);
        chk("t1 aw_hs_cyc", 64'(aw_hs_cyc - c0), 64'd1);
        chk("t1 w_hs_cyc", 64'(w_hs_cyc - c0), 64'd1);
        chk("t1 slave reg0", 64'(sregs[0]), 64'd1);

        // write then read back from another requester, unaligned byte address
        set_req(0, 1'b1, 4'h4, 32'h0000_0002);
        run(3'b001, 1, "t2w", c0, fd);
        set_req(1, 1'b0, 4'h5, 32'h0);
        run(3'b010, 1, "t2r", c0, fd);
        chk("t2 latency", 64'(fd - c0), 64'd3);
        chk("t2 araddr", 64'(ar_addr_l), 64'h4);

        // two requesters held continuously
        set_req(0, 1'b1, 4'h8, 32'h0000_00A0);
        set_req(1, 1'b1, 4'hC, 32'h0000_00B1);
        run(3'b011, 4, "t3", c0, fd);

        // WREADY three cycles after AWREADY
        w_delay = 3;
        aw0 = aw_cyc; w0 = w_cyc; b0 = b_count;
        set_req(0, 1'b1, 4'h8, 32'h0000_00C0);
        run(3'b001, 1, "t4", c0, fd);
        chk("t4 awvalid cycles", 64'(aw_cyc - aw0), 64'd1);
        chk("t4 wvalid cycles", 64'(w_cyc - w0), 64'd4);
        chk("t4 w after aw", 64'(w_hs_cyc - aw_hs_cyc), 64'd3);
        chk("t4 b accepted", 64'(b_count - b0), 64'd1);
        w_delay = 0;

        // error response
        bresp_cfg = 2'b10;
        set_req(2, 1'b1, 4'hC, 32'h0000_0005);
        run(3'b100, 1, "t5", c0, fd);
        bresp_cfg = 2'b00;

        // reset while waiting for B
        b_hold = 1'b1;
        set_req(0, 1'b1, 4'h0, 32'h0000_0009);
        @(posedge ACLK); #1;
        req_valid = 3'b001;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge ACLK);
            if (axi.bready) seen = 1'b1;
        end
        chk("t5r in wresp", 64'(seen), 64'd1);
        dn0 = done_cnt;
        ARESETN = 1'b0;
        #1;
        chk("t5r outs", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
                             req_done, req_resp, req_rdata}), 64'd0);
        req_valid = '0;
        b_hold    = 1'b0;
        repeat (2) @(negedge ACLK);
        ARESETN   = 1'b1;
        mdl_ptr   = 0;
        mdl_rdata = '0;
        repeat (5) @(negedge ACLK);
        chk("t5r no done", 64'(done_cnt - dn0), 64'd0);

        // req0 and req2 held: alternates under round-robin, req0 only under fixed priority
        set_req(0, 1'b0, 4'h4, 32'h0);
        set_req(2, 1'b0, 4'hC, 32'h0);
        run(3'b101, 3, "t6", c0, fd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
